// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline: per-stage {flush,stall} controls, PC hold/redirect,
// a RUN/DISCARD FSM that drops a wrong-path fetch still in flight, and stall/flush perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_MemRead,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_branch_taken,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  output logic                 pc_stall,
  output logic                 pc_redirect,
  output logic [1:0]           ifid_fs,
  output logic [1:0]           idex_fs,
  output logic [1:0]           exmem_fs,
  output logic [1:0]           memwb_fs,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events,
  output logic                 dbg_state_o
);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  localparam logic [1:0] FS_RUN   = 2'b00;
  localparam logic [1:0] FS_STALL = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use;

  // x0 never carries a real load result, so it cannot create a hazard.
  assign load_use = ex_MemRead && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    ifid_fs     = FS_RUN;
    idex_fs     = FS_RUN;
    exmem_fs    = FS_RUN;
    memwb_fs    = FS_RUN;
    state_d     = state_q;

    if (reset) begin
      pc_stall = 1'b1;
      ifid_fs  = FS_FLUSH;
      idex_fs  = FS_FLUSH;
      exmem_fs = FS_FLUSH;
      memwb_fs = FS_FLUSH;
      state_d  = S_RUN;
    end else begin
      if (mem_busy) begin
        // EX is held, so a pending branch or load-use is simply re-seen next cycle.
        pc_stall = 1'b1;
        ifid_fs  = FS_STALL;
        idex_fs  = FS_STALL;
        exmem_fs = FS_STALL;
        memwb_fs = FS_FLUSH;
      end else if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_fs     = FS_FLUSH;
        idex_fs     = FS_FLUSH;
        if (if_busy) state_d = S_DISCARD;
      end else if (load_use) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_STALL;
        idex_fs  = FS_FLUSH;
      end else if (if_busy) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_FLUSH;
      end

      // The word arriving from the abandoned fetch must never enter ID.
      if (state_q == S_DISCARD) begin
        ifid_fs = FS_FLUSH;
        if (mem_busy || !ex_branch_taken) pc_stall = pc_stall | if_busy;
        state_d = if_busy ? S_DISCARD : S_RUN;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pc_stall};
    flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pc_redirect};
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic, every cycle
// compared against a table-driven priority model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int W = 11;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken, if_busy, mem_busy;
  logic        pc_stall, pc_redirect;
  logic [1:0]  ifid_fs, idex_fs, exmem_fs, memwb_fs;
  logic [31:0] stall_cycles, flush_events;
  logic        dbg_state_o;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic        m_disc;
  logic [31:0] m_stalls, m_flushes;
  logic [W-1:0] exp_q[$];

  // Per-cause action table, cause 1..5 = mem_busy, branch, load-use, if_busy, idle.
  logic       t_stall[1:5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       t_redir[1:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] t_ifid [1:5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [1:0] t_idex [1:5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [1:0] t_exmem[1:5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] t_memwb[1:5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00};

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_MemRead     (ex_MemRead),
    .ex_rd_addr     (ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .if_busy        (if_busy),
    .mem_busy       (mem_busy),
    .pc_stall       (pc_stall),
    .pc_redirect    (pc_redirect),
    .ifid_fs        (ifid_fs),
    .idex_fs        (idex_fs),
    .exmem_fs       (exmem_fs),
    .memwb_fs       (memwb_fs),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Driver
  task automatic set_in(input logic rst, input logic mb, input logic br, input logic ib,
                        input logic mr, input int rd, input int r1, input int r2,
                        input logic u1, input logic u2);
    reset = rst; mem_busy = mb; ex_branch_taken = br; if_busy = ib; ex_MemRead = mr;
    ex_rd_addr = 5'(rd); id_rs1_addr = 5'(r1); id_rs2_addr = 5'(r2);
    id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  // One cycle: predict, compare away from the edge, then advance the model on the edge.
  task automatic step();
    int         cause;
    logic       lu, s, rdr, nd;
    logic [1:0] f0, f1, f2, f3;
    logic [W-1:0] e, got;
    lu = ex_MemRead && (ex_rd_addr != 0) &&
         ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    cause = mem_busy ? 1 : ex_branch_taken ? 2 : lu ? 3 : if_busy ? 4 : 5;
    s = t_stall[cause]; rdr = t_redir[cause];
    f0 = t_ifid[cause]; f1 = t_idex[cause]; f2 = t_exmem[cause]; f3 = t_memwb[cause];
    if (m_disc) begin
      f0 = 2'b10;
      if (cause != 2) s = s | if_busy;
      nd = if_busy;
    end else begin
      nd = (cause == 2) && if_busy;
    end
    if (reset) begin
      s = 1'b1; rdr = 1'b0; f0 = 2'b10; f1 = 2'b10; f2 = 2'b10; f3 = 2'b10; nd = 1'b0;
    end
    exp_q.push_back({s, rdr, f0, f1, f2, f3, m_disc});

    @(negedge clk);
    e   = exp_q.pop_front();
    got = {pc_stall, pc_redirect, ifid_fs, idex_fs, exmem_fs, memwb_fs, dbg_state_o};
    check("pc_stall", 64'(got[10]), 64'(e[10]));
    check("pc_redirect", 64'(got[9]), 64'(e[9]));
    check("ifid_fs", 64'(got[8:7]), 64'(e[8:7]));
    check("idex_fs", 64'(got[6:5]), 64'(e[6:5]));
    check("exmem_fs", 64'(got[4:3]), 64'(e[4:3]));
    check("memwb_fs", 64'(got[2:1]), 64'(e[2:1]));
    check("state", 64'(got[0]), 64'(e[0]));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    check("flush_events", 64'(flush_events), 64'(m_flushes));

    @(posedge clk);
    if (reset) begin
      m_disc = 1'b0; m_stalls = '0; m_flushes = '0;
    end else begin
      m_disc    = nd;
      m_stalls  = m_stalls + 32'(s);
      m_flushes = m_flushes + 32'(rdr);
    end
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    m_disc = 1'b0; m_stalls = '0; m_flushes = '0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    idle();

    // Load-use on rs1, then x0 load which must not stall.
    set_in(0, 0, 0, 0, 1, 5, 5, 0, 1, 0); step();
    check("lu_stall_count", 64'(stall_cycles), 64'd1);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 1, 7, 3, 7, 1, 1); step();
    set_in(0, 0, 0, 0, 1, 7, 3, 7, 1, 0); step();

    // Branch with no fetch in flight.
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); step();
    check("br_flush_count", 64'(flush_events), 64'd1);
    idle();

    // Branch while fetch busy for 3 cycles.
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check("discard_exit", 64'(dbg_state_o), 64'd0);
    idle();

    // mem_busy masks a simultaneous branch and load-use until it drops.
    set_in(0, 1, 1, 0, 1, 4, 4, 0, 1, 0); step();
    step();
    set_in(0, 0, 1, 0, 1, 4, 4, 0, 1, 0); step();
    idle();

    // Reset in the middle of DISCARD with nonzero counters.
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    step();
    idle();
    check("rst_stalls", 64'(stall_cycles), 64'd0);
    check("rst_flushes", 64'(flush_events), 64'd0);

    // Random traffic with narrow register range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
